// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a small synchronous FIFO with a valid/ready input handshake.
// Line and busy outputs are registered, so they trail the FSM state by one clock.
module uart_tx_fifo #(
    parameter int BAUD_DIV = 434,
    parameter int FIFO_LG  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       busy
);
    localparam int DEPTH = 1 << FIFO_LG;
    localparam int CW    = ($clog2(BAUD_DIV) > 0) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [7:0]       mem [DEPTH];
    logic [FIFO_LG:0] wr_ptr, rd_ptr;
    logic [CW-1:0]    baud_cnt, baud_next;
    logic [2:0]       bit_cnt, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             ready_en;
    logic             full, empty, push, pop, line_next;

    // ready_en keeps tx_ready low from reset assertion until the first edge after release
    assign full     = (wr_ptr[FIFO_LG] != rd_ptr[FIFO_LG]) &&
                      (wr_ptr[FIFO_LG-1:0] == rd_ptr[FIFO_LG-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign tx_ready = ready_en & ~full;
    assign push     = tx_valid & tx_ready;

    // Storage is deliberately not reset; emptiness is tracked by the pointers alone
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[FIFO_LG-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            ready_en   <= 1'b0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            ready_en   <= 1'b1;
            serial_out <= line_next;
            busy       <= (state != IDLE) || !empty;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr[FIFO_LG-1:0]];
                    baud_next  = BAUD_LOAD;
                    state_next = START;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    baud_next  = BAUD_LOAD;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt - CW'(1);
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_next  = BAUD_LOAD;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_next = baud_cnt - CW'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data is queued
                if (baud_cnt == '0) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr[FIFO_LG-1:0]];
                        baud_next  = BAUD_LOAD;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        line_next = 1'b1;
        case (state)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_reg[0];
            default: line_next = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_DIV=4, FIFO_LG=2: cycle table for one frame,
// plus handshake/back-pressure, pointer wrap and mid-frame reset sequences checked via a line decoder.
module tb_uart_tx_fifo;
    logic       clock = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       serial_out;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    int         gap_q[$];

    typedef struct {
        int   cyc;
        logic ser;
        logic bsy;
        logic rdy;
    } vec_t;

    vec_t vec[18];

    uart_tx_fifo #(.BAUD_DIV(4), .FIFO_LG(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Holds tx_valid with data d until accepted; e tracks the index of the last edge
    task automatic push_byte(input logic [7:0] d, inout int e);
        logic r;
        r = 1'b0;
        tx_valid = 1'b1;
        tx_data  = d;
        for (int k = 0; k < 200; k++) begin
            r = tx_ready;
            step();
            e++;
            if (r) break;
        end
        check_output("push handshake", {31'd0, r}, 32'd1);
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int k = 0; k < budget && rx_q.size() < n; k++) begin
            @(negedge clock);
        end
        check_output("rx byte count", rx_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (!busy) break;
        end
        check_output("busy idle", {31'd0, busy}, 32'd0);
    endtask

    // Line decoder: samples one cycle into each bit, records idle gap before each start bit
    initial begin
        logic [7:0] rx_byte;
        int rx_cnt;
        int idle_cnt;
        bit rx_active;
        rx_byte = '0;
        rx_cnt = 0;
        idle_cnt = 0;
        rx_active = 0;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                rx_active = 0;
                idle_cnt = 0;
            end else if (!rx_active) begin
                if (serial_out == 1'b0) begin
                    rx_active = 1;
                    rx_cnt = 0;
                    gap_q.push_back(idle_cnt);
                end else begin
                    idle_cnt++;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= 5 && rx_cnt <= 33 && ((rx_cnt - 5) % 4) == 0) begin
                    rx_byte[3'((rx_cnt - 5) / 4)] = serial_out;
                end else if (rx_cnt == 37) begin
                    check_output("stop bit", {31'd0, serial_out}, 32'd1);
                    rx_q.push_back(rx_byte);
                    rx_active = 0;
                    idle_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e;
        int cur;
        logic r;
        bit saw_low;
        int exp_edge[6];
        logic [7:0] exp6[6];

        // Single 0xA5 frame, byte accepted at edge 0 (cycle k = value after edge k)
        vec[0]  = '{0,  1'b1, 1'b0, 1'b1};
        vec[1]  = '{1,  1'b1, 1'b1, 1'b1};
        vec[2]  = '{2,  1'b0, 1'b1, 1'b1};
        vec[3]  = '{5,  1'b0, 1'b1, 1'b1};
        vec[4]  = '{6,  1'b1, 1'b1, 1'b1};
        vec[5]  = '{9,  1'b1, 1'b1, 1'b1};
        vec[6]  = '{10, 1'b0, 1'b1, 1'b1};
        vec[7]  = '{14, 1'b1, 1'b1, 1'b1};
        vec[8]  = '{18, 1'b0, 1'b1, 1'b1};
        vec[9]  = '{22, 1'b0, 1'b1, 1'b1};
        vec[10] = '{26, 1'b1, 1'b1, 1'b1};
        vec[11] = '{30, 1'b0, 1'b1, 1'b1};
        vec[12] = '{34, 1'b1, 1'b1, 1'b1};
        vec[13] = '{37, 1'b1, 1'b1, 1'b1};
        vec[14] = '{38, 1'b1, 1'b1, 1'b1};
        vec[15] = '{41, 1'b1, 1'b1, 1'b1};
        vec[16] = '{42, 1'b1, 1'b0, 1'b1};
        vec[17] = '{43, 1'b1, 1'b0, 1'b1};

        exp_edge = '{0, 1, 2, 3, 4, 42};

        reset = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;

        repeat (3) @(posedge clock);
        #2;
        check_output("reset serial_out", {31'd0, serial_out}, 32'd1);
        check_output("reset tx_ready", {31'd0, tx_ready}, 32'd0);
        check_output("reset busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b1;
        #1;
        check_output("ready before first edge", {31'd0, tx_ready}, 32'd0);
        step();
        check_output("ready after first edge", {31'd0, tx_ready}, 32'd1);
        check_output("idle serial_out", {31'd0, serial_out}, 32'd1);

        // Frame timing table
        rx_q.delete();
        gap_q.delete();
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clock);
        #1;
        tx_valid = 1'b0;
        cur = -1;
        for (int i = 0; i < 18; i++) begin
            while (cur < vec[i].cyc) begin
                @(negedge clock);
                cur++;
            end
            check_output($sformatf("serial_out cycle %0d", vec[i].cyc), {31'd0, serial_out}, {31'd0, vec[i].ser});
            check_output($sformatf("busy cycle %0d", vec[i].cyc), {31'd0, busy}, {31'd0, vec[i].bsy});
            check_output($sformatf("tx_ready cycle %0d", vec[i].cyc), {31'd0, tx_ready}, {31'd0, vec[i].rdy});
        end
        wait_rx(1, 100);
        check_output("A5 decoded", {24'd0, rx_q[0]}, 32'hA5);
        wait_idle(100);

        // Six bytes with tx_valid held: back-pressure after 5, refill after STOP pop
        step();
        rx_q.delete();
        gap_q.delete();
        e = -1;
        for (int i = 0; i < 6; i++) begin
            push_byte(8'(i + 1), e);
            check_output($sformatf("accept edge byte %0d", i + 1), e, exp_edge[i]);
        end
        check_output("full after refill", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        wait_rx(6, 500);
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("stream byte %0d", i), {24'd0, rx_q[i]}, i + 1);
        end
        for (int i = 1; i < 6; i++) begin
            check_output($sformatf("idle gap before frame %0d", i), gap_q[i], 2);
        end
        wait_idle(200);

        // Push coinciding with pop at occupancy 2, then a 20-byte stream wrapping the pointers
        step();
        rx_q.delete();
        gap_q.delete();
        e = -1;
        push_byte(8'h00, e);
        push_byte(8'h01, e);
        push_byte(8'h02, e);
        tx_valid = 1'b0;
        while (e < 40) begin
            step();
            e++;
        end
        push_byte(8'h03, e);
        check_output("push/pop edge", e, 41);
        check_output("ready at occupancy 2", {31'd0, tx_ready}, 32'd1);
        push_byte(8'h04, e);
        push_byte(8'h05, e);
        check_output("full after two more", {31'd0, tx_ready}, 32'd0);
        for (int i = 6; i < 20; i++) begin
            push_byte(8'(i), e);
        end
        tx_valid = 1'b0;
        wait_rx(20, 1500);
        for (int i = 0; i < 20; i++) begin
            check_output($sformatf("wrap byte %0d", i), {24'd0, rx_q[i]}, i);
        end
        wait_idle(200);

        // Reset in DATA bit 3 of 0x3C with two bytes queued
        step();
        rx_q.delete();
        gap_q.delete();
        e = -1;
        push_byte(8'h3C, e);
        push_byte(8'hAA, e);
        push_byte(8'hBB, e);
        tx_valid = 1'b0;
        while (e < 18) begin
            step();
            e++;
        end
        #2;
        reset = 1'b0;
        #1;
        check_output("abort serial_out", {31'd0, serial_out}, 32'd1);
        check_output("abort busy", {31'd0, busy}, 32'd0);
        check_output("abort tx_ready", {31'd0, tx_ready}, 32'd0);
        step();
        step();
        check_output("held serial_out", {31'd0, serial_out}, 32'd1);
        check_output("held busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        #1;
        check_output("release ready before edge", {31'd0, tx_ready}, 32'd0);
        step();
        check_output("release ready after edge", {31'd0, tx_ready}, 32'd1);
        saw_low = 0;
        repeat (80) begin
            @(negedge clock);
            if (serial_out !== 1'b1) saw_low = 1;
        end
        check_output("no frame after reset", {31'd0, saw_low}, 32'd0);
        check_output("busy after reset", {31'd0, busy}, 32'd0);
        check_output("nothing decoded", rx_q.size(), 0);
        step();
        e = -1;
        push_byte(8'h5A, e);
        tx_valid = 1'b0;
        wait_rx(1, 100);
        check_output("first byte after reset", {24'd0, rx_q[0]}, 32'h5A);
        wait_idle(100);

        // tx_data changes every cycle while blocked; only the accepting-edge value counts
        step();
        rx_q.delete();
        gap_q.delete();
        exp6 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'h2A};
        e = -1;
        for (int i = 0; i < 5; i++) begin
            push_byte(exp6[i], e);
        end
        r = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tx_data = 8'(e + 1);
            r = tx_ready;
            step();
            e++;
            if (r) break;
        end
        tx_valid = 1'b0;
        check_output("blocked accept handshake", {31'd0, r}, 32'd1);
        check_output("blocked accept edge", e, 42);
        wait_rx(6, 500);
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("sampled byte %0d", i), {24'd0, rx_q[i]}, {24'd0, exp6[i]});
        end
        wait_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter BAUD_DIV, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_LG, default 2, log2 of FIFO depth (depth = 4 by default); legal range 1..6.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_valid  input  1  upstream byte offered (driven by the SoC host-interface tx_valid).
REQ-006 tx_data  input  8  byte offered; meaningful only when tx_valid=1.
REQ-007 tx_ready  output  1  block can accept a byte this cycle.
REQ-008 serial_out  output  1  UART line, 8N1, idle high.
REQ-009 busy  output  1  FIFO non-empty or frame in progress.

Function
REQ-010 Handshake: a byte is accepted in every cycle where tx_valid=1 and tx_ready=1; there are no other acceptance conditions.
REQ-011 tx_ready SHALL equal !full, combinationally from registered FIFO state; it SHALL NOT depend on tx_valid.
REQ-012 FIFO: 2^FIFO_LG entries; read and write pointers are FIFO_LG+1 bits wide and wrap modulo 2^(FIFO_LG+1); full = MSBs differ and low bits equal; empty = pointers equal.
REQ-013 Push and pop in the same cycle SHALL both take effect; the occupancy is unchanged.
REQ-014 When full, a pop frees a slot; tx_ready rises in the following cycle, never in the same cycle.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE transition: in IDLE with the FIFO non-empty, pop the head into an 8-bit shift register and enter START on the next edge.
REQ-017 START: serial_out=0 for exactly BAUD_DIV cycles, then enter DATA.
REQ-018 DATA: 8 bits, LSB first, each held exactly BAUD_DIV cycles; a 3-bit bit counter counts 0..7; after bit 7, enter STOP.
REQ-019 STOP: serial_out=1 for exactly BAUD_DIV cycles.
REQ-020 End of STOP with the FIFO non-empty: pop the next byte and enter START directly, with no idle gap. End of STOP with the FIFO empty: enter IDLE.
REQ-021 Baud counter: loads BAUD_DIV-1 on every state or bit entry and decrements; a bit ends when the counter reaches 0; the width is ceil(log2(BAUD_DIV)) bits (minimum 1).
REQ-022 serial_out SHALL be a registered output; it is 1 in IDLE and STOP.
REQ-023 Latency: a byte accepted at edge N into an empty FIFO with FSM in IDLE causes serial_out=0 from edge N+2.
REQ-024 A full frame lasts exactly 10*BAUD_DIV cycles.
REQ-025 busy SHALL be a registered output, equal to (state!=IDLE) or FIFO non-empty.
REQ-026 Bytes SHALL be transmitted in acceptance order, with none dropped or duplicated.
REQ-027 tx_data SHALL be sampled only on an accepted handshake; changes on tx_data while tx_ready=0 have no effect.

Reset
REQ-028 While reset=0, outputs SHALL be held immediately and asynchronously at serial_out=1, tx_ready=0, busy=0.
REQ-029 While reset=0, state=IDLE, both pointers=0, and the baud counter, bit counter and shift register=0.
REQ-030 After reset deasserts, tx_ready=1 from the first rising edge; reset release is synchronous to clock.
REQ-031 Reset asserted mid-frame SHALL abort the frame, with the line returning high at once, and SHALL discard all FIFO contents.
REQ-032 FIFO contents are not cleared; only the pointers are reset.

Verification (bench uses BAUD_DIV=4, FIFO_LG=2)
REQ-033 Single byte 0xA5 accepted at cycle 0 -> serial_out low at cycles 2-5, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high at cycles 38-41; busy falls at cycle 42.
REQ-034 tx_valid held high with bytes 0x01..0x06 -> tx_ready falls after 5 accepts (4 in FIFO, 1 popped); frames are back-to-back with no idle between stop and start; the line decodes 0x01..0x06 in order.
REQ-035 FIFO full while a STOP ends with tx_valid=1 -> the pop occurs, tx_ready=1 on the next cycle, and the new byte is accepted; occupancy returns to 4 with no loss.
REQ-036 Push at the same cycle as a pop at occupancy 2 -> occupancy stays 2; the 20-byte stream 0x00..0x13 decodes in order; pointer wrap is exercised.
REQ-037 reset pulsed low during DATA bit 3 of 0x3C with 2 bytes queued -> serial_out=1 within the same cycle, busy=0; after release, no frame is emitted until a new byte is accepted.
REQ-038 tx_valid=1 at cycle k with tx_ready=0 and tx_data changed at k+1 -> only the value present at the accepting edge is transmitted.
